// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle for mac_seq_ctrl: job command, operand stream, multiplier
// issue/return path and result handshake. The slave modport is the
// sequencer's view; the master modport is its environment.
interface mac_seq_ctrl_if #(
  parameter int LENW = 8,
  parameter int ACCW = 24
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [LENW-1:0] cmd_len;

  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_a;
  logic [7:0]      in_b;

  logic            mul_valid;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic            mul_rsp_valid;
  logic [15:0]     mul_rsp;

  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_sum;

  modport master (
    output cmd_valid, cmd_len, in_valid, in_a, in_b,
           mul_rsp_valid, mul_rsp, res_ready,
    input  cmd_ready, in_ready, mul_valid, mul_a, mul_b,
           res_valid, res_sum
  );

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b,
           mul_rsp_valid, mul_rsp, res_ready,
    output cmd_ready, in_ready, mul_valid, mul_a, mul_b,
           res_valid, res_sum
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one multiply-accumulate job at a time. A job of
// cmd_len operand pairs is streamed out to an external 8x8 multiplier;
// products come back in order after a fixed latency and are summed into an
// ACCW-bit accumulator, which is presented as res_sum when all have returned.
// Configuration macro MACSEQ_SAT_EN: when defined the accumulator saturates
// at all-ones, otherwise it wraps modulo 2^ACCW.
// ACCW is expected to be at least 16 so a single product always fits.
module mac_seq_ctrl #(
  parameter int LENW = 8,
  parameter int ACCW = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.slave  bus,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [LENW-1:0] ONE_LEN = LENW'(1);

  state_t          state_reg, state_next;
  logic [LENW-1:0] len_reg, len_next;
  logic [LENW-1:0] issue_cnt_reg, issue_cnt_next;
  logic [LENW-1:0] ret_cnt_reg, ret_cnt_next;
  logic [ACCW-1:0] acc_reg, acc_next;
  logic [ACCW-1:0] res_sum_reg, res_sum_next;
  logic            err_reg, err_next;
  logic            mul_valid_reg;
  logic [7:0]      mul_a_reg, mul_b_reg;

  logic            cmd_ready_w, in_ready_w, res_valid_w;
  logic            in_hs;
  logic            rsp_take;
  logic            rsp_spurious;
  logic [ACCW-1:0] acc_add;

  // Handshake readiness is a pure function of the state.
  assign cmd_ready_w = (state_reg == IDLE);
  assign in_ready_w  = (state_reg == ISSUE);
  assign res_valid_w = (state_reg == DONE);
  assign in_hs       = bus.in_valid & in_ready_w;

  // A product is only accepted while a job is collecting and not all of its
  // products have come back yet; anything else is flagged as spurious.
  assign rsp_take     = bus.mul_rsp_valid &
                        ((state_reg == ISSUE) || (state_reg == DRAIN)) &
                        (ret_cnt_reg != len_reg);
  assign rsp_spurious = bus.mul_rsp_valid & ~rsp_take;

`ifdef MACSEQ_SAT_EN
  logic [ACCW:0] acc_wide;

  // Saturating add: a carry out of the accumulator clamps it to all-ones.
  always_comb begin
    acc_wide = {1'b0, acc_reg} + (ACCW + 1)'(bus.mul_rsp);
    acc_add  = acc_wide[ACCW] ? {ACCW{1'b1}} : acc_wide[ACCW-1:0];
  end
`else
  // Wrapping add: the carry out of the accumulator is simply dropped.
  always_comb begin
    acc_add = acc_reg + ACCW'(bus.mul_rsp);
  end
`endif

  // Next-state and next-datapath decode for the job sequencer.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    issue_cnt_next = issue_cnt_reg;
    ret_cnt_next   = ret_cnt_reg;
    acc_next       = acc_reg;
    res_sum_next   = res_sum_reg;
    err_next       = err_reg | rsp_spurious;

    if (rsp_take) begin
      acc_next     = acc_add;
      ret_cnt_next = ret_cnt_reg + ONE_LEN;
    end

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          len_next       = bus.cmd_len;
          issue_cnt_next = '0;
          ret_cnt_next   = '0;
          acc_next       = '0;
          if (bus.cmd_len == '0) begin
            res_sum_next = '0;
            state_next   = DONE;
          end else begin
            state_next   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (in_hs) begin
          issue_cnt_next = issue_cnt_reg + ONE_LEN;
          if (issue_cnt_next == len_reg) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // ret_cnt_next already includes a product arriving this cycle.
        if (ret_cnt_next == len_reg) begin
          res_sum_next = acc_next;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state, counters, accumulator, result and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      acc_reg       <= '0;
      res_sum_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      issue_cnt_reg <= issue_cnt_next;
      ret_cnt_reg   <= ret_cnt_next;
      acc_reg       <= acc_next;
      res_sum_reg   <= res_sum_next;
      err_reg       <= err_next;
    end
  end

  // Multiplier issue stage: one-cycle pulse carrying the accepted operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_valid_reg <= 1'b0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
    end else begin
      mul_valid_reg <= in_hs;
      if (in_hs) begin
        mul_a_reg <= bus.in_a;
        mul_b_reg <= bus.in_b;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.res_valid = res_valid_w;
  assign bus.res_sum   = res_sum_reg;
  assign bus.mul_valid = mul_valid_reg;
  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign busy          = (state_reg != IDLE);
  assign err           = err_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl. Two instances (ACCW=16 and ACCW=24) see
// identical stimulus; each has its own 3-cycle multiplier model that is not
// cleared by rst_n, so products in flight survive a reset of the sequencer.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_len;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic        res_ready;
  logic        inj_valid;
  logic [15:0] inj_val;

  int errors = 0;
  int checks = 0;
  int mv_cnt = 0;
  int mv_base;

`ifdef MACSEQ_SAT_EN
  localparam logic [31:0] EXP_OVF16 = 32'h0000_FFFF;
`else
  localparam logic [31:0] EXP_OVF16 = 32'h0000_FC02;
`endif

  logic [7:0] tog_a [4] = '{8'd1, 8'd3, 8'd10, 8'd100};
  logic [7:0] tog_b [4] = '{8'd2, 8'd4, 8'd20, 8'd200};

  mac_seq_ctrl_if #(.LENW(8), .ACCW(16)) bus16 ();
  mac_seq_ctrl_if #(.LENW(8), .ACCW(24)) bus24 ();
  logic busy16, err16, busy24, err24;

  mac_seq_ctrl #(.LENW(8), .ACCW(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16), .err(err16)
  );
  mac_seq_ctrl #(.LENW(8), .ACCW(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .bus(bus24), .busy(busy24), .err(err24)
  );

  assign bus16.cmd_valid = cmd_valid;  assign bus24.cmd_valid = cmd_valid;
  assign bus16.cmd_len   = cmd_len;    assign bus24.cmd_len   = cmd_len;
  assign bus16.in_valid  = in_valid;   assign bus24.in_valid  = in_valid;
  assign bus16.in_a      = in_a;       assign bus24.in_a      = in_a;
  assign bus16.in_b      = in_b;       assign bus24.in_b      = in_b;
  assign bus16.res_ready = res_ready;  assign bus24.res_ready = res_ready;

  // Multiplier models: three register stages from mul_valid to mul_rsp_valid.
  logic [2:0]  pv16 = '0, pv24 = '0;
  logic [15:0] pp16 [3] = '{default: '0};
  logic [15:0] pp24 [3] = '{default: '0};

  always @(posedge clk) begin
    pv16    <= {pv16[1:0], bus16.mul_valid};
    pp16[0] <= 16'(bus16.mul_a) * 16'(bus16.mul_b);
    pp16[1] <= pp16[0];
    pp16[2] <= pp16[1];
    pv24    <= {pv24[1:0], bus24.mul_valid};
    pp24[0] <= 16'(bus24.mul_a) * 16'(bus24.mul_b);
    pp24[1] <= pp24[0];
    pp24[2] <= pp24[1];
    if (bus16.mul_valid) mv_cnt <= mv_cnt + 1;
  end

  assign bus16.mul_rsp_valid = pv16[2] | inj_valid;
  assign bus16.mul_rsp       = inj_valid ? inj_val : pp16[2];
  assign bus24.mul_rsp_valid = pv24[2] | inj_valid;
  assign bus24.mul_rsp       = inj_valid ? inj_val : pp24[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_accept_busy", 32'(busy16), 32'd1);
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("issue_mul_valid", 32'(bus16.mul_valid), 32'd1);
    chk("issue_mul_a", 32'(bus16.mul_a), 32'(a));
    chk("issue_mul_b", 32'(bus16.mul_b), 32'(b));
  endtask

  task automatic finish_job(input string tag, input logic [31:0] exp16, input logic [31:0] exp24);
    int n;
    n = 0;
    while (!(bus16.res_valid && bus24.res_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(n < 40), 32'd1);
    chk({tag, "_sum16"}, 32'(bus16.res_sum), exp16);
    chk({tag, "_sum24"}, 32'(bus24.res_sum), exp24);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_valid"}, 32'(bus16.res_valid), 32'd1);
    chk({tag, "_hold_sum"}, 32'(bus16.res_sum), exp16);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_released_valid"}, 32'(bus16.res_valid), 32'd0);
    chk({tag, "_released_busy"}, 32'(busy16), 32'd0);
    $display("job %s: res_sum16=%0d res_sum24=%0d err=%0d", tag,
             bus16.res_sum, bus24.res_sum, err16);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0; inj_valid = 1'b0; inj_val = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_cmd_ready", 32'(bus16.cmd_ready), 32'd1);
    chk("rst_in_ready", 32'(bus16.in_ready), 32'd0);
    chk("rst_mul_valid", 32'(bus16.mul_valid), 32'd0);
    chk("rst_mul_a", 32'(bus16.mul_a), 32'd0);
    chk("rst_res_valid", 32'(bus16.res_valid), 32'd0);
    chk("rst_res_sum", 32'(bus24.res_sum), 32'd0);
    chk("rst_err", 32'(err24), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // len=3, back-to-back operands: 6 + 20 + 65025.
    mv_base = mv_cnt;
    send_cmd(8'd3);
    chk("len3_in_ready", 32'(bus16.in_ready), 32'd1);
    feed(8'd2, 8'd3);
    feed(8'd4, 8'd5);
    feed(8'd255, 8'd255);
    chk("len3_drain_in_ready", 32'(bus16.in_ready), 32'd0);
    finish_job("len3", 32'd65051, 32'd65051);
    chk("len3_pulses", 32'(mv_cnt - mv_base), 32'd3);

    // len=0: straight to DONE with a zero result and no issue.
    mv_base = mv_cnt;
    send_cmd(8'd0);
    chk("len0_res_valid", 32'(bus16.res_valid), 32'd1);
    finish_job("len0", 32'd0, 32'd0);
    chk("len0_pulses", 32'(mv_cnt - mv_base), 32'd0);

    // len=4 with in_valid toggling: 2 + 12 + 200 + 20000.
    mv_base = mv_cnt;
    send_cmd(8'd4);
    for (int i = 0; i < 4; i++) begin
      feed(tog_a[i], tog_b[i]);
      @(negedge clk);
      chk("toggle_gap_mul_valid", 32'(bus16.mul_valid), 32'd0);
    end
    finish_job("len4_toggle", 32'd20214, 32'd20214);
    chk("len4_pulses", 32'(mv_cnt - mv_base), 32'd4);

    // Overflow of the 16-bit accumulator: 2 * 65025 = 0x1FC02.
    send_cmd(8'd2);
    feed(8'd255, 8'd255);
    feed(8'd255, 8'd255);
    finish_job("overflow", EXP_OVF16, 32'd130050);

    // Reset mid-job after 2 of 5 issues; both products return afterwards.
    chk("pre_abort_err", 32'(err16), 32'd0);
    send_cmd(8'd5);
    feed(8'd3, 8'd5);
    feed(8'd2, 8'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_mul_valid", 32'(bus16.mul_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_err_before_stale", 32'(err16), 32'd0);
    @(negedge clk);
    chk("stale_err16", 32'(err16), 32'd1);
    chk("stale_err24", 32'(err24), 32'd1);
    chk("stale_idle_cmd_ready", 32'(bus16.cmd_ready), 32'd1);
    chk("stale_idle_busy", 32'(busy24), 32'd0);
    @(negedge clk);
    send_cmd(8'd1);
    feed(8'd7, 8'd6);
    finish_job("after_abort", 32'd42, 32'd42);
    chk("err_sticky", 32'(err16), 32'd1);

    // Spurious product while idle: flagged, not accumulated.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("err_cleared_by_reset", 32'(err16), 32'd0);
    @(negedge clk);
    inj_valid = 1'b1;
    inj_val   = 16'h1234;
    @(negedge clk);
    inj_valid = 1'b0;
    chk("idle_rsp_err", 32'(err16), 32'd1);
    chk("idle_rsp_busy", 32'(busy16), 32'd0);
    send_cmd(8'd2);
    feed(8'd9, 8'd9);
    feed(8'd1, 8'd1);
    finish_job("after_idle_rsp", 32'd82, 32'd82);
    chk("idle_rsp_err_sticky", 32'(err24), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter LENW, default 8: width of the job-length field.
REQ-002 SHALL have parameter ACCW, default 24: width of the accumulator and result.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: job request.
REQ-006 SHALL have port cmd_ready, output, 1: job accepted when cmd_valid & cmd_ready are both high.
REQ-007 SHALL have port cmd_len, input, LENW: number of operand pairs in the job.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_a input 8, in_b input 8: operand stream, unsigned int8.
REQ-009 SHALL have ports mul_valid output 1, mul_a output 8, mul_b output 8: issue interface to the 8x8 multiplier datapath.
REQ-010 SHALL have ports mul_rsp_valid input 1, mul_rsp input 16: product return, in issue order, at any fixed latency >= 1.
REQ-011 SHALL have ports res_valid output 1, res_ready input 1, res_sum output ACCW: job result.
REQ-012 SHALL have ports busy output 1 and err output 1: busy is high in any state except IDLE; err is a sticky spurious-response flag.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-014 In IDLE: cmd_ready=1. On cmd handshake: latch cmd_len, clear the accumulator and both counters, then go to ISSUE (len>0) or directly to DONE with res_sum=0 (len==0).
REQ-015 In ISSUE: in_ready=1; cmd_ready, in_ready and res_valid SHALL be 0 in every other state where not stated.
REQ-016 Each in handshake SHALL register in_a/in_b onto mul_a/mul_b and pulse mul_valid for exactly one cycle, on the cycle after the handshake.
REQ-017 The issue counter SHALL increment per handshake; on the handshake that reaches len, go to DRAIN (in_ready drops the next cycle).
REQ-018 In ISSUE or DRAIN, each mul_rsp_valid SHALL add zero-extended mul_rsp to the accumulator and increment the return counter.
REQ-019 Leaving DRAIN: when the return count reaches len (including a response on the same cycle as the last issue), go to DONE with the final sum registered.
REQ-020 In DONE: res_valid=1 and res_sum stable until res_ready; on res_valid & res_ready, go to IDLE; back-to-back jobs SHALL add no extra idle cycle beyond the IDLE state itself.
REQ-021 mul_rsp_valid in IDLE or DONE SHALL be ignored for accumulation and SHALL set err=1.
REQ-022 A response arriving when the return count already equals len SHALL be treated the same as REQ-021.
REQ-023 The accumulator SHALL be ACCW bits wide; overflow behaviour is set by REQ-027.

Reset
REQ-024 While rst_n=0, the block SHALL hold: state=IDLE, counters=0, accumulator=0, mul_valid=0, mul_a=mul_b=0, res_valid=0, res_sum=0, err=0, busy=0.
REQ-025 Reset asserted mid-job SHALL abort the job with no result produced; products still in flight that return afterwards SHALL set err per REQ-021.
REQ-026 err SHALL clear only by reset.

Configuration
REQ-027 Macro MACSEQ_SAT_EN: when defined, the accumulator SHALL saturate at 2^ACCW-1 and hold; when undefined, it SHALL wrap modulo 2^ACCW.

Verification
REQ-028 Job len=3, pairs (2,3),(4,5),(255,255), multiplier latency 3 -> res_sum=65051, res_valid held until res_ready, then busy=0.
REQ-029 Job len=0 -> DONE on the cycle after acceptance, res_sum=0, no mul_valid pulse.
REQ-030 Job len=4, in_valid toggling 1/0 each cycle -> exactly 4 mul_valid pulses, each one cycle after its handshake, mul_a/mul_b matching the inputs.
REQ-031 ACCW=16, len=2, pairs (255,255),(255,255) -> res_sum=0xFFFF with MACSEQ_SAT_EN, 0xFC02 without.
REQ-032 rst_n pulsed low after 2 of 5 issues, then 2 stale responses arrive -> err=1, state IDLE, next job len=1 with (7,6) -> res_sum=42.
REQ-033 mul_rsp_valid injected while in IDLE -> err=1, accumulator unchanged, next job result correct.
